gs_column_orth: RTL and testbench

// Parametrised Gram-Schmidt pre-normalisation stage for the QR unit of the ZF detector.

---
 rtl/gs_pkg.sv | 28 ++
 rtl/gs_mac_unit.sv | 36 +++
 rtl/gs_column_orth.sv | 145 ++++++++++++++
 tb/tb_gs_column_orth.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// Shared types, default sizing and the saturation helper for the Gram-Schmidt
// pre-normalisation stage.
package gs_pkg;

  localparam int unsigned DefNElem   = 4;
  localparam int unsigned DefW       = 16;
  localparam int unsigned DefFrac    = 8;
  localparam int unsigned DefMaxPrev = 3;

  typedef enum logic [2:0] {StIdle, StLoad, StDot, StUpdate, StDone} gs_state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_w(input logic signed [63:0] x,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      sat_w = hi;
    end else if (x < lo) begin
      sat_w = lo;
    end else begin
      sat_w = x;
    end
  endfunction

endpackage

// File: rtl/gs_mac_unit.sv
// Shared multiplier: accumulates r*q for the dot product, or subtracts the
// scaled projection dot*q from a residual element, with fixed-point saturation.
module gs_mac_unit import gs_pkg::*; #(
  parameter int unsigned W     = DefW,
  parameter int unsigned FRAC  = DefFrac,
  parameter int unsigned ACC_W = 2 * DefW + 2
) (
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    sub_mode,
  output logic signed [ACC_W-1:0] acc_sum,
  output logic signed [W-1:0]     result,
  output logic                    sat
);

  logic signed [2*W-1:0] prod;
  logic signed [63:0]    prod64;
  logic signed [63:0]    acc64;
  logic signed [63:0]    wide;
  logic signed [63:0]    clamped;

  always_comb begin
    prod    = a * b;
    acc_sum = acc + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
    prod64  = {{(64 - 2 * W){prod[2*W-1]}}, prod};
    // In subtract mode acc carries the sign-extended residual element.
    acc64   = sub_mode ? {{(64 - ACC_W){acc[ACC_W-1]}}, acc}
                       : {{(64 - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
    wide    = sub_mode ? acc64 - (prod64 >>> FRAC) : acc64 >>> FRAC;
    clamped = sat_w(wide, W);
    result  = clamped[W-1:0];
    sat     = (clamped != wide);
  end

endmodule

// File: rtl/gs_column_orth.sv
// Modified Gram-Schmidt projection removal: strips up to MAX_PREV normalised Q
// columns from h, element-serial through one shared multiplier.
module gs_column_orth import gs_pkg::*; #(
  parameter int unsigned N_ELEM   = DefNElem,
  parameter int unsigned W        = DefW,
  parameter int unsigned FRAC     = DefFrac,
  parameter int unsigned MAX_PREV = DefMaxPrev
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  output logic                                 accept_out,
  output logic                                 ready_out,
  input  logic                                 accept_in,
  input  logic [$clog2(MAX_PREV+1)-1:0]        num_prev,
  input  logic [N_ELEM*W-1:0]                  h_col,
  input  logic [MAX_PREV*N_ELEM*W-1:0]         q_cols,
  output logic [N_ELEM*W-1:0]                  q_pre,
  output logic                                 sat_flag
);

  localparam int unsigned PW    = $clog2(MAX_PREV + 1);
  localparam int unsigned IW    = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int unsigned ACC_W = 2 * W + IW;
  localparam logic [PW-1:0] MaxP  = PW'(MAX_PREV);
  localparam logic [IW-1:0] LastI = IW'(N_ELEM - 1);

  gs_state_e state_q, state_d;

  logic signed [W-1:0]     r_q [N_ELEM];
  logic signed [W-1:0]     q_q [MAX_PREV][N_ELEM];
  logic [PW-1:0]           p_q, k_q, p_load;
  logic [IW-1:0]           i_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W-1:0]     dot_q;
  logic                    sat_q;
  logic                    last_i, last_k;

  logic signed [W-1:0]     mac_a, mac_b, mac_result;
  logic signed [ACC_W-1:0] mac_acc, mac_acc_sum;
  logic                    mac_sub, mac_sat;

  always_comb begin
    p_load  = (num_prev > MaxP) ? MaxP : num_prev;
    last_i  = (i_q == LastI);
    last_k  = (k_q == p_q - PW'(1));
    mac_sub = (state_q == StUpdate);
    mac_a   = mac_sub ? dot_q : r_q[i_q];
    mac_b   = q_q[k_q][i_q];
    mac_acc = mac_sub ? {{(ACC_W - W){r_q[i_q][W-1]}}, r_q[i_q]} : acc_q;
  end

  gs_mac_unit #(
    .W     (W),
    .FRAC  (FRAC),
    .ACC_W (ACC_W)
  ) u_mac (
    .a        (mac_a),
    .b        (mac_b),
    .acc      (mac_acc),
    .sub_mode (mac_sub),
    .acc_sum  (mac_acc_sum),
    .result   (mac_result),
    .sat      (mac_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (enable) state_d = StLoad;
      StLoad:   state_d = (p_load != '0) ? StDot : StDone;
      StDot:    if (last_i) state_d = StUpdate;
      StUpdate: if (last_i) state_d = last_k ? StDone : StDot;
      StDone:   if (accept_in) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < N_ELEM; e++) begin
        r_q[e] <= '0;
        for (int k = 0; k < MAX_PREV; k++) q_q[k][e] <= '0;
      end
      p_q   <= '0;
      k_q   <= '0;
      i_q   <= '0;
      acc_q <= '0;
      dot_q <= '0;
      sat_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          for (int e = 0; e < N_ELEM; e++) begin
            r_q[e] <= h_col[e*W +: W];
            for (int k = 0; k < MAX_PREV; k++) q_q[k][e] <= q_cols[(k*N_ELEM+e)*W +: W];
          end
          p_q   <= p_load;
          k_q   <= '0;
          i_q   <= '0;
          acc_q <= '0;
          sat_q <= 1'b0;
        end
        StDot: begin
          acc_q <= mac_acc_sum;
          i_q   <= i_q + 1'b1;
          if (last_i) begin
            dot_q <= mac_result;
            sat_q <= sat_q | mac_sat;
            i_q   <= '0;
          end
        end
        StUpdate: begin
          r_q[i_q] <= mac_result;
          sat_q    <= sat_q | mac_sat;
          i_q      <= i_q + 1'b1;
          if (last_i) begin
            i_q   <= '0;
            acc_q <= '0;
            if (!last_k) k_q <= k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_pre = '0;
    for (int e = 0; e < N_ELEM; e++) q_pre[e*W +: W] = r_q[e];
  end

  assign accept_out = (state_q == StIdle);
  assign ready_out  = (state_q == StDone);
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_gs_column_orth.sv
// Self-checking bench for gs_column_orth: directed spec cases, randomized jobs
// against an integer reference model, handshake and mid-job reset.
module tb_gs_column_orth;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MP = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              accept_in = 1'b0;
  logic [1:0]        num_prev = '0;
  logic [N*W-1:0]    h_col = '0;
  logic [MP*N*W-1:0] q_cols = '0;
  wire               accept_out, ready_out, sat_flag;
  wire  [N*W-1:0]    q_pre;

  always #5 clk = ~clk;

  gs_column_orth dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .accept_out (accept_out),
    .ready_out  (ready_out),
    .accept_in  (accept_in),
    .num_prev   (num_prev),
    .h_col      (h_col),
    .q_cols     (q_cols),
    .q_pre      (q_pre),
    .sat_flag   (sat_flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cur_h [N];
  int cur_q [MP][N];
  int exp_r [N];
  bit exp_sat;
  int exp_lat;
  int obs_lat;
  bit obs_to;

  function automatic int sat16(input longint x);
    if (x > 32767) begin
      exp_sat = 1'b1;
      return 32767;
    end
    if (x < -32768) begin
      exp_sat = 1'b1;
      return -32768;
    end
    return int'(x);
  endfunction

  // Reference: r = h; for each k: dot = sat(<r,q_k> >>> 8); r_i = sat(r_i - (dot*q_k_i >>> 8)).
  task automatic model(input int np);
    int p;
    longint d;
    int dot;
    p = (np > MP) ? MP : np;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++) exp_r[i] = cur_h[i];
    for (int k = 0; k < p; k++) begin
      d = 0;
      for (int i = 0; i < N; i++) d += longint'(exp_r[i]) * longint'(cur_q[k][i]);
      dot = sat16(d >>> 8);
      for (int i = 0; i < N; i++)
        exp_r[i] = sat16(longint'(exp_r[i]) - ((longint'(dot) * longint'(cur_q[k][i])) >>> 8));
    end
    exp_lat = 2 + 2 * N * p;
  endtask

  function automatic logic [N*W-1:0] exp_vec();
    logic [N*W-1:0] v;
    int t;
    for (int i = 0; i < N; i++) begin
      t = exp_r[i];
      v[i*W +: W] = t[W-1:0];
    end
    return v;
  endfunction

  task automatic load_inputs(input int np);
    int t;
    for (int i = 0; i < N; i++) begin
      t = cur_h[i];
      h_col[i*W +: W] = t[W-1:0];
      for (int k = 0; k < MP; k++) begin
        t = cur_q[k][i];
        q_cols[(k*N+i)*W +: W] = t[W-1:0];
      end
    end
    num_prev = 2'(np);
  endtask

  task automatic set_case(input int c, output int np);
    for (int i = 0; i < N; i++) begin
      cur_h[i] = 0;
      for (int k = 0; k < MP; k++) cur_q[k][i] = 0;
    end
    case (c)
      0: begin np = 0; cur_h = '{256, 512, 768, 1024}; end
      1, 5: begin np = 1; cur_q[0][0] = 256; cur_h = '{512, 256, -256, 128}; end
      2, 3: begin
        np = (c == 2) ? 2 : 7;
        cur_q[0][0] = 256;
        cur_q[1][1] = 256;
        cur_h = '{512, 256, 768, -128};
      end
      default: begin np = 1; cur_q[0][0] = 512; cur_h = '{32767, 0, 0, 0}; end
    endcase
  endtask

  // Start a job and wait for ready_out; obs_lat counts cycles after the enable edge.
  task automatic run_job(input int np, input bit disturb);
    @(negedge clk);
    load_inputs(np);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    obs_lat = 1;
    while (ready_out !== 1'b1 && obs_lat < 200) begin
      @(negedge clk);
      obs_lat++;
      enable = 1'b0;
      if (disturb && obs_lat == 4) begin
        enable   = 1'b1;
        h_col    = {$urandom, $urandom};
        num_prev = 2'd0;
      end
    end
    enable = 1'b0;
    obs_to = (ready_out !== 1'b1);
    model(np);
  endtask

  task automatic accept_job();
    @(negedge clk);
    accept_in = 1'b1;
    @(negedge clk);
    accept_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (accept_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_accept_out: got %b expected 1", accept_out);
    end
    n_tests++;
    if (ready_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_out: got %b expected 0", ready_out);
    end
    n_tests++;
    if (q_pre !== '0) begin
      n_fail++; $display("FAIL reset_q_pre: got %h expected 0", q_pre);
    end
    n_tests++;
    if (sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL reset_sat_flag: got %b expected 0", sat_flag);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int np;
    for (int c = 0; c < 6; c++) begin
      set_case(c, np);
      run_job(np, 1'b0);
      n_tests++;
      if (obs_to || obs_lat !== exp_lat) begin
        n_fail++; $display("FAIL directed%0d_latency: got %0d expected %0d", c, obs_lat, exp_lat);
      end
      n_tests++;
      if (q_pre !== exp_vec()) begin
        n_fail++; $display("FAIL directed%0d_q_pre: got %h expected %h", c, q_pre, exp_vec());
      end
      n_tests++;
      if (sat_flag !== exp_sat) begin
        n_fail++; $display("FAIL directed%0d_sat_flag: got %b expected %b", c, sat_flag, exp_sat);
      end
      accept_job();
    end
  endtask

  task automatic test_random();
    int np;
    bit big;
    for (int j = 0; j < 40; j++) begin
      np  = int'($urandom_range(3));
      big = ($urandom_range(3) == 0);
      for (int i = 0; i < N; i++) begin
        cur_h[i] = big ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(4095)) - 2048;
        for (int k = 0; k < MP; k++)
          cur_q[k][i] = big ? int'($urandom_range(8191)) - 4096 : int'($urandom_range(512)) - 256;
      end
      run_job(np, 1'b0);
      n_tests++;
      if (obs_to || obs_lat !== exp_lat) begin
        n_fail++; $display("FAIL random%0d_latency: got %0d expected %0d", j, obs_lat, exp_lat);
      end
      n_tests++;
      if (q_pre !== exp_vec()) begin
        n_fail++; $display("FAIL random%0d_q_pre: got %h expected %h", j, q_pre, exp_vec());
      end
      n_tests++;
      if (sat_flag !== exp_sat) begin
        n_fail++; $display("FAIL random%0d_sat_flag: got %b expected %b", j, sat_flag, exp_sat);
      end
      accept_job();
    end
  endtask

  task automatic test_handshake();
    int np;
    set_case(2, np);
    run_job(np, 1'b1);
    n_tests++;
    if (obs_to || obs_lat !== exp_lat) begin
      n_fail++; $display("FAIL hs_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    for (int c = 0; c < 5; c++) begin
      h_col = {$urandom, $urandom};
      @(negedge clk);
      n_tests++;
      if (ready_out !== 1'b1 || q_pre !== exp_vec()) begin
        n_fail++;
        $display("FAIL hs_hold%0d: got ready=%b q_pre=%h expected ready=1 q_pre=%h",
                 c, ready_out, q_pre, exp_vec());
      end
    end
    accept_in = 1'b1;
    enable    = 1'b1;
    @(negedge clk);
    accept_in = 1'b0;
    enable    = 1'b0;
    n_tests++;
    if (accept_out !== 1'b1 || ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_release: got accept_out=%b ready_out=%b expected 1 0", accept_out, ready_out);
    end
    n_tests++;
    if (q_pre !== exp_vec()) begin
      n_fail++; $display("FAIL hs_q_pre_kept: got %h expected %h", q_pre, exp_vec());
    end
    @(negedge clk);
    n_tests++;
    if (accept_out !== 1'b1) begin
      n_fail++; $display("FAIL hs_enable_in_done: got accept_out=%b expected 1", accept_out);
    end
  endtask

  task automatic test_reset_mid_job();
    int np;
    set_case(4, np);
    run_job(np, 1'b0);
    accept_job();
    set_case(2, np);
    @(negedge clk);
    load_inputs(np);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (accept_out !== 1'b1 || ready_out !== 1'b0 || q_pre !== '0 || sat_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: got accept=%b ready=%b q_pre=%h sat=%b expected 1 0 0 0",
               accept_out, ready_out, q_pre, sat_flag);
    end
    reset = 1'b0;
    set_case(1, np);
    run_job(np, 1'b0);
    n_tests++;
    if (obs_to || obs_lat !== exp_lat) begin
      n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", obs_lat, exp_lat);
    end
    n_tests++;
    if (q_pre !== exp_vec() || sat_flag !== exp_sat) begin
      n_fail++;
      $display("FAIL midreset_result: got %h sat=%b expected %h sat=%b",
               q_pre, sat_flag, exp_vec(), exp_sat);
    end
    accept_job();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
